alu_seq: RTL

- Next-generation execute unit; replaces the purely combinational ALU in the EX stage.
- Parametrised in datapath width.
- Accepts one operation per valid/ready handshake:
  - single-cycle integer ops return one cycle after acceptance;
  - RV32M multiply/divide ops run on an iterative shift-add/shift-subtract engine.
- Result, branch decision and an illegal flag are registered and held until the consumer takes them.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_muldiv_iter.sv | 125 ++++++++++++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the sequential execute unit.
// Operation codes, branch types and the control-FSM state enum.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_AND    = 5'd0,
    ALU_OR     = 5'd1,
    ALU_ADD    = 5'd2,
    ALU_XOR    = 5'd3,
    ALU_SLL    = 5'd4,
    ALU_SRL    = 5'd5,
    ALU_SRA    = 5'd6,
    ALU_SUB    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JAL  = 3'd7
  } branch_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative multiply/divide engine (one bit per cycle).
// Only instantiated when ALU_MULDIV_EN is defined. Works on operand
// magnitudes; signs are re-applied in the fix cycle that follows the
// last iteration. 'last' flags the final iteration, 'done' the fix cycle
// in which 'res' is valid.
import alu_pkg::*;

module alu_muldiv_iter #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            last,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  logic [XLEN-1:0]   ma_r;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]   acc_r;     // product high half or partial remainder
  logic [XLEN-1:0]   lo_r;      // multiplier/product low half or quotient
  logic [CNT_W-1:0]  cnt_r;
  logic              run_r, fix_r, is_div_r, sel_r, neg_r, neg_rem_r;

  logic              sgn_a_s, sgn_b_s, is_div_s, sel_s, neg1_s, neg2_s;
  logic [XLEN-1:0]   mag1_s, mag2_s;
  logic [XLEN:0]     mul_sum_s, div_sh_s;
  logic [XLEN+1:0]   div_diff_s;
  logic              div_ge_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  // decode operand signedness and result selection, form magnitudes
  always_comb begin
    sgn_a_s  = 1'b0;
    sgn_b_s  = 1'b0;
    is_div_s = 1'b0;
    sel_s    = 1'b0;
    case (op)
      ALU_MUL:    begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
      ALU_MULH:   begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; sel_s = 1'b1; end
      ALU_MULHSU: begin sgn_a_s = 1'b1; sel_s = 1'b1; end
      ALU_MULHU:  begin sel_s = 1'b1; end
      ALU_DIV:    begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; is_div_s = 1'b1; end
      ALU_DIVU:   begin is_div_s = 1'b1; end
      ALU_REM:    begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; is_div_s = 1'b1; sel_s = 1'b1; end
      ALU_REMU:   begin is_div_s = 1'b1; sel_s = 1'b1; end
      default:    begin sel_s = 1'b0; end
    endcase
    neg1_s = sgn_a_s & op1[XLEN-1];
    neg2_s = sgn_b_s & op2[XLEN-1];
    mag1_s = neg1_s ? -op1 : op1;
    mag2_s = neg2_s ? -op2 : op2;
  end

  // one shift-add / restoring-subtract step and the final sign fix
  always_comb begin
    mul_sum_s  = {1'b0, acc_r} + (lo_r[0] ? {1'b0, ma_r} : {(XLEN+1){1'b0}});
    div_sh_s   = {acc_r, lo_r[XLEN-1]};
    div_diff_s = {1'b0, div_sh_s} - {2'b00, ma_r};
    div_ge_s   = ~div_diff_s[XLEN+1];
    prod_s     = neg_r ? -{acc_r, lo_r} : {acc_r, lo_r};
    quo_s      = neg_r ? -lo_r : lo_r;
    rem_s      = neg_rem_r ? -acc_r : acc_r;
    if (is_div_r) begin
      res = sel_r ? rem_s : quo_s;
    end else begin
      res = sel_r ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
  end

  assign last = run_r & (cnt_r == LAST_CNT);
  assign done = fix_r;

  // operand capture on start, then XLEN iterations, then one fix cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_r      <= '0;
      acc_r     <= '0;
      lo_r      <= '0;
      cnt_r     <= '0;
      run_r     <= 1'b0;
      fix_r     <= 1'b0;
      is_div_r  <= 1'b0;
      sel_r     <= 1'b0;
      neg_r     <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (start) begin
      ma_r      <= is_div_s ? mag2_s : mag1_s;
      lo_r      <= is_div_s ? mag1_s : mag2_s;
      acc_r     <= '0;
      cnt_r     <= '0;
      run_r     <= 1'b1;
      fix_r     <= 1'b0;
      is_div_r  <= is_div_s;
      sel_r     <= sel_s;
      neg_r     <= neg1_s ^ neg2_s;
      neg_rem_r <= neg1_s;
    end else if (run_r) begin
      if (is_div_r) begin
        acc_r <= div_ge_s ? div_diff_s[XLEN-1:0] : div_sh_s[XLEN-1:0];
        lo_r  <= {lo_r[XLEN-2:0], div_ge_s};
      end else begin
        acc_r <= mul_sum_s[XLEN:1];
        lo_r  <= {mul_sum_s[0], lo_r[XLEN-1:1]};
      end
      if (cnt_r == LAST_CNT) begin
        run_r <= 1'b0;
        fix_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end else begin
      fix_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential execute unit with valid/ready handshake.
// Fast integer ops complete one cycle after acceptance; M-extension ops
// use alu_muldiv_iter when ALU_MULDIV_EN is defined, otherwise they are
// reported as illegal. Result, branch decision and illegal flag are held
// until the consumer takes them.
import alu_pkg::*;

module alu_seq #(
  parameter int XLEN    = 32,
  parameter int OP_W    = 5,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] alu_op,
  input  logic [2:0]      branch,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            take_branch,
  output logic            illegal,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_r;
  logic            accept_s, go_iter_s, imm_ill_s, br_s;
  logic [XLEN-1:0] imm_res_s;

  assign in_ready = (state_r == S_IDLE) | ((state_r == S_DONE) & out_ready);
  assign accept_s = in_valid & in_ready;

  // single-cycle results, divide special cases, and engine dispatch
  always_comb begin
    imm_res_s = '0;
    imm_ill_s = 1'b0;
    go_iter_s = 1'b0;
    case (alu_op)
      ALU_AND:  imm_res_s = op1 & op2;
      ALU_OR:   imm_res_s = op1 | op2;
      ALU_XOR:  imm_res_s = op1 ^ op2;
      ALU_ADD:  imm_res_s = op1 + op2;
      ALU_SUB:  imm_res_s = op1 - op2;
      ALU_SLL:  imm_res_s = op1 << op2[SHAMT_W-1:0];
      ALU_SRL:  imm_res_s = op1 >> op2[SHAMT_W-1:0];
      ALU_SRA:  imm_res_s = $unsigned($signed(op1) >>> op2[SHAMT_W-1:0]);
      ALU_SLT:  imm_res_s = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: imm_res_s = {{(XLEN-1){1'b0}}, (op1 < op2)};
`ifdef ALU_MULDIV_EN
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: go_iter_s = 1'b1;
      ALU_DIV, ALU_DIVU: begin
        if (op2 == '0) begin
          imm_res_s = '1;
        end else if ((alu_op == ALU_DIV) && (op1 == MIN_V) && (op2 == '1)) begin
          imm_res_s = MIN_V;
        end else begin
          go_iter_s = 1'b1;
        end
      end
      ALU_REM, ALU_REMU: begin
        if (op2 == '0) begin
          imm_res_s = op1;
        end else if ((alu_op == ALU_REM) && (op1 == MIN_V) && (op2 == '1)) begin
          imm_res_s = '0;
        end else begin
          go_iter_s = 1'b1;
        end
      end
`endif
      default:  imm_ill_s = 1'b1;
    endcase
  end

  // branch decision straight from the operands, independent of alu_op
  always_comb begin
    br_s = 1'b0;
    case (branch)
      BR_BEQ:  br_s = (op1 == op2);
      BR_BNE:  br_s = (op1 != op2);
      BR_BLT:  br_s = ($signed(op1) <  $signed(op2));
      BR_BGE:  br_s = ($signed(op1) >= $signed(op2));
      BR_BLTU: br_s = (op1 <  op2);
      BR_BGEU: br_s = (op1 >= op2);
      BR_JAL:  br_s = 1'b1;
      default: br_s = 1'b0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic            eng_last_s, eng_done_s;
  logic [XLEN-1:0] eng_res_s;

  alu_muldiv_iter #(.XLEN(XLEN), .OP_W(OP_W)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept_s & go_iter_s),
    .op    (alu_op),
    .op1   (op1),
    .op2   (op2),
    .last  (eng_last_s),
    .done  (eng_done_s),
    .res   (eng_res_s)
  );

  assign busy = (state_r == S_BUSY) | (state_r == S_FIX);
`else
  assign busy = 1'b0;
`endif

  // control FSM with registered result, branch and illegal outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      take_branch <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            take_branch <= br_s;
            illegal     <= imm_ill_s;
            if (go_iter_s) begin
              state_r   <= S_BUSY;
              out_valid <= 1'b0;
            end else begin
              state_r   <= S_DONE;
              out_valid <= 1'b1;
              result    <= imm_res_s;
            end
          end else if ((state_r == S_DONE) && out_ready) begin
            state_r   <= S_IDLE;
            out_valid <= 1'b0;
          end else begin
            state_r   <= state_r;
          end
        end
`ifdef ALU_MULDIV_EN
        S_BUSY: begin
          if (eng_last_s) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_BUSY;
          end
        end
        S_FIX: begin
          if (eng_done_s) begin
            result    <= eng_res_s;
            out_valid <= 1'b1;
            state_r   <= S_DONE;
          end else begin
            state_r   <= S_FIX;
          end
        end
`endif
        default: begin
          state_r   <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
